// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO console/finish peripheral: default register
// addresses and the UART transmitter state encoding.
package mmio_pkg;

  localparam logic [31:0] CONSOLE_ADDR_DEF = 32'h0020_0000;
  localparam logic [31:0] FINISH_ADDR_DEF  = 32'h1000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/mmio_console_uart_if.sv
// DCCM store snoop port seen by the console peripheral.
//
// Handshake: dccm_wen is the valid strobe for one store (address and data
// qualify with it). mmio_stall is the inverse of ready: a store transfers on
// a rising clk edge where dccm_wen=1 and mmio_stall=0; while mmio_stall=1 the
// LSU holds dccm_wen, dccm_waddr and dccm_wdata stable.
interface mmio_console_uart_if #(
  parameter int XLEN = 32
) ();

  logic            dccm_wen;
  logic [XLEN-1:0] dccm_waddr;
  logic [XLEN-1:0] dccm_wdata;
  logic            mmio_stall;

  // LSU side: drives stores, receives back-pressure.
  modport master (
    output dccm_wen,
    output dccm_waddr,
    output dccm_wdata,
    input  mmio_stall
  );

  // Peripheral side: snoops stores, returns back-pressure.
  modport slave (
    input  dccm_wen,
    input  dccm_waddr,
    input  dccm_wdata,
    output mmio_stall
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; push and pop may coincide,
// including a push on a full FIFO when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             wr_en;
  logic             rd_en;

  // Equal indices with differing wrap bits means the writer lapped the reader.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // Pointer advance.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/mmio_console_uart.sv
// Console + finish peripheral snooping DCCM stores. Console bytes queue in a
// FIFO and leave on an 8N1 UART; a finish write latches a sticky exit code.
// Build option: define MMIO_CONSOLE_STALL_EN to back-pressure the LSU instead
// of dropping bytes when the console FIFO is full.
module mmio_console_uart
  import mmio_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] CONSOLE_ADDR = CONSOLE_ADDR_DEF,
  parameter logic [XLEN-1:0] FINISH_ADDR  = FINISH_ADDR_DEF,
  parameter int              FIFO_DEPTH   = 16,
  parameter int              CLKS_PER_BIT = 868
) (
  input  logic                clk,
  input  logic                rst_n,
  mmio_console_uart_if.slave  dccm,
  output logic                uart_tx,
  output logic                console_busy,
  output logic [7:0]          drop_cnt,
  output logic                finish,
  output logic [XLEN-1:0]     finish_code,
  output uart_state_e         tx_state
);

  localparam int              BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  uart_state_e       state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic [7:0]        drop_q, drop_d;
  logic              finish_q, finish_d;
  logic [XLEN-1:0]   code_q, code_d;

  logic              console_hit;
  logic              finish_hit;
  logic              push_req;
  logic              pop;
  logic              drop_ev;
  logic              stall;
  logic              baud_last;
  logic              fifo_full;
  logic              fifo_empty;
  logic [7:0]        fifo_rdata;

  assign console_hit = dccm.dccm_wen && (dccm.dccm_waddr == CONSOLE_ADDR);
  assign finish_hit  = dccm.dccm_wen && (dccm.dccm_waddr == FINISH_ADDR);

`ifdef MMIO_CONSOLE_STALL_EN
  // Hold the LSU only while a full FIFO cannot drain this cycle from IDLE.
  assign stall = fifo_full && (state_q != IDLE);
`else
  assign stall = 1'b0;
`endif

  assign dccm.mmio_stall = stall;
  assign push_req        = console_hit && !stall;
  assign drop_ev         = push_req && fifo_full && !pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_req),
    .pop   (pop),
    .wdata (dccm.dccm_wdata[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign baud_last = (baud_q == BAUD_LAST);

  // TX next-state: frame sequencing, FIFO pop and the registered line level.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rdata;
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          baud_d    = '0;
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) state_d = STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          baud_d = '0;
          // Chain straight into the next frame so queued bytes leave gap-free.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        baud_d  = '0;
      end
    endcase

    // Line level follows the state being entered, so uart_tx is a flop.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // Sticky finish capture and saturating drop counter.
  always_comb begin
    finish_d = finish_q;
    code_d   = code_q;
    drop_d   = drop_q;
    if (finish_hit && !finish_q) begin
      finish_d = 1'b1;
      code_d   = dccm.dccm_wdata;
    end
    if (drop_ev && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      drop_q    <= '0;
      finish_q  <= 1'b0;
      code_q    <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      drop_q    <= drop_d;
      finish_q  <= finish_d;
      code_q    <= code_d;
    end
  end

  assign uart_tx      = tx_q;
  assign console_busy = !fifo_empty || (state_q != IDLE);
  assign drop_cnt     = drop_q;
  assign finish       = finish_q;
  assign finish_code  = code_q;
  assign tx_state     = state_q;

endmodule

// File: tb/tb_mmio_console_uart.sv
// Bench for mmio_console_uart with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_mmio_console_uart;
  import mmio_pkg::*;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_finish;
    logic [31:0] exp_code;
  } fin_vec_t;

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;
  } frame_vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mmio_console_uart_if #(.XLEN(32)) bus ();

  logic        uart_tx;
  logic        console_busy;
  logic [7:0]  drop_cnt;
  logic        finish;
  logic [31:0] finish_code;
  uart_state_e tx_state;

  mmio_console_uart #(
    .XLEN         (32),
    .CONSOLE_ADDR (32'h0020_0000),
    .FINISH_ADDR  (32'h1000_0000),
    .FIFO_DEPTH   (4),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dccm         (bus),
    .uart_tx      (uart_tx),
    .console_busy (console_busy),
    .drop_cnt     (drop_cnt),
    .finish       (finish),
    .finish_code  (finish_code),
    .tx_state     (tx_state)
  );

  // ---------------- scoreboard ----------------
  int   checks = 0;
  int   errors = 0;
  bit   saw_stall = 1'b0;
  logic [9:0] exp_q[$];

  fin_vec_t   fin_tab [7];
  frame_vec_t fv [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- driver tasks ----------------
  // One store; held while the peripheral stalls. Returns at edge+1.
  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    bit stalled;
    bit done;
    done = 1'b0;
    bus.dccm_waddr = addr;
    bus.dccm_wdata = data;
    bus.dccm_wen   = 1'b1;
    for (int w = 0; w < 500; w++) begin
      stalled = bus.mmio_stall;
      if (stalled) saw_stall = 1'b1;
      @(posedge clk);
      #1;
      if (!stalled) begin
        done = 1'b1;
        break;
      end
    end
    bus.dccm_wen = 1'b0;
    if (!done) fail_now("store_timeout");
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int w = 0; w < 200; w++) begin
      if (uart_tx === 1'b0) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) fail_now("frame_start_timeout");
  endtask

  // Captures one frame mid-bit and compares against the head of exp_q.
  // Returns at offset 37 of the frame (inside the stop bit).
  task automatic capture_frame(output int start);
    bit         ok;
    logic [9:0] bits;
    logic [9:0] exp;
    bits = '0;
    wait_start(ok);
    start = cyc;
    if (ok) begin
      for (int k = 0; k < 10; k++) begin
        repeat (k == 0 ? 1 : CPB) begin
          @(posedge clk);
          #1;
        end
        bits[k] = uart_tx;
      end
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame actual=0x%0h expected=none", bits);
      end else begin
        exp = exp_q.pop_front();
        check("frame_bits", 32'(bits), 32'(exp));
      end
    end
  endtask

  task automatic capture_n(input int n);
    int st;
    int prev;
    prev = 0;
    for (int i = 0; i < n; i++) begin
      capture_frame(st);
      if (i > 0) check("frame_spacing", 32'(st - prev), 32'(FRAME));
      prev = st;
    end
  endtask

  task automatic idle_watch(input string name, input int n);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (uart_tx !== 1'b1) lows++;
    end
    check(name, 32'(lows), 32'd0);
  endtask

  // Global bound in case a wait escapes its own limit.
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int nsent;
    int exp_drop;
    bit exp_stall;
    bit ok;

    bus.dccm_wen   = 1'b0;
    bus.dccm_waddr = '0;
    bus.dccm_wdata = '0;

    fin_tab[0] = '{1'b1, 32'h1000_0004, 32'h0000_0005, 1'b0, 32'h0};
    fin_tab[1] = '{1'b1, 32'h0020_0001, 32'h0000_0041, 1'b0, 32'h0};
    fin_tab[2] = '{1'b0, 32'h1000_0000, 32'h0000_0077, 1'b0, 32'h0};
    fin_tab[3] = '{1'b0, 32'h0020_0000, 32'h0000_0041, 1'b0, 32'h0};
    fin_tab[4] = '{1'b1, 32'h1000_0000, 32'h0000_DEAD, 1'b1, 32'h0000_DEAD};
    fin_tab[5] = '{1'b1, 32'h1000_0000, 32'h0000_BEEF, 1'b1, 32'h0000_DEAD};
    fin_tab[6] = '{1'b1, 32'h1000_0004, 32'h0000_1234, 1'b1, 32'h0000_DEAD};

    // frame = {stop, data[7:0], start}, bit 0 sent first
    fv[0]  = '{8'h41, 10'b1010000010};
    fv[1]  = '{8'h48, 10'b1010010000};
    fv[2]  = '{8'h69, 10'b1011010010};
    fv[3]  = '{8'h0A, 10'b1000010100};
    fv[4]  = '{8'h30, 10'b1001100000};
    fv[5]  = '{8'h31, 10'b1001100010};
    fv[6]  = '{8'h32, 10'b1001100100};
    fv[7]  = '{8'h33, 10'b1001100110};
    fv[8]  = '{8'h34, 10'b1001101000};
    fv[9]  = '{8'h35, 10'b1001101010};
    fv[10] = '{8'h36, 10'b1001101100};
    fv[11] = '{8'h37, 10'b1001101110};
    fv[12] = '{8'h55, 10'b1010101010};

`ifdef MMIO_CONSOLE_STALL_EN
    nsent     = 8;
    exp_drop  = 0;
    exp_stall = 1'b1;
`else
    nsent     = 5;
    exp_drop  = 3;
    exp_stall = 1'b0;
`endif

    // Reset state
    rst_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("rst_uart_tx", 32'(uart_tx), 32'd1);
    check("rst_busy", 32'(console_busy), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst_finish", 32'(finish), 32'd0);
    check("rst_finish_code", finish_code, 32'd0);
    check("rst_stall", 32'(bus.mmio_stall), 32'd0);
    check("rst_state", 32'(tx_state), 32'(IDLE));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Decode and finish vectors
    for (int i = 0; i < 7; i++) begin
      bus.dccm_wen   = fin_tab[i].wen;
      bus.dccm_waddr = fin_tab[i].addr;
      bus.dccm_wdata = fin_tab[i].data;
      @(posedge clk);
      #1;
      bus.dccm_wen = 1'b0;
      check($sformatf("fin%0d_finish", i), 32'(finish), 32'(fin_tab[i].exp_finish));
      check($sformatf("fin%0d_code", i), finish_code, fin_tab[i].exp_code);
      check($sformatf("fin%0d_busy", i), 32'(console_busy), 32'd0);
    end
    idle_watch("decode_no_tx", 10);

    // Single byte after finish: exact start latency, frame, busy release
    exp_q.push_back(fv[0].frame);
    store(32'h0020_0000, 32'(fv[0].data));
    check("single_tx_high_after_store", 32'(uart_tx), 32'd1);
    check("single_busy_after_store", 32'(console_busy), 32'd1);
    @(posedge clk);
    #1;
    check("single_start_latency", 32'(uart_tx), 32'd0);
    capture_n(1);
    repeat (2) @(posedge clk);
    #1;
    check("single_busy_last_stop", 32'(console_busy), 32'd1);
    @(posedge clk);
    #1;
    check("single_busy_fall", 32'(console_busy), 32'd0);
    check("single_state_idle", 32'(tx_state), 32'(IDLE));
    check("finish_kept", 32'(finish), 32'd1);

    // Back-to-back "Hi\n"
    for (int i = 1; i <= 3; i++) exp_q.push_back(fv[i].frame);
    fork
      begin
        for (int i = 1; i <= 3; i++) store(32'h0020_0000, 32'(fv[i].data));
      end
      capture_n(3);
    join
    repeat (2) @(posedge clk);
    #1;
    check("b2b_busy_last_stop", 32'(console_busy), 32'd1);
    @(posedge clk);
    #1;
    check("b2b_busy_fall", 32'(console_busy), 32'd0);
    check("b2b_exp_q_empty", 32'(exp_q.size()), 32'd0);

    // Overflow: 8 consecutive stores into a depth-4 FIFO
    for (int i = 0; i < nsent; i++) exp_q.push_back(fv[4 + i].frame);
    fork
      begin
        for (int i = 0; i < 8; i++) store(32'h0020_0000, 32'(fv[4 + i].data));
      end
      capture_n(nsent);
    join
    repeat (3) @(posedge clk);
    #1;
    check("ovf_busy_fall", 32'(console_busy), 32'd0);
    check("ovf_drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    check("ovf_saw_stall", 32'(saw_stall), 32'(exp_stall));
    check("ovf_exp_q_empty", 32'(exp_q.size()), 32'd0);
    idle_watch("ovf_no_extra_frame", FRAME + 5);

    // Reset mid-frame during DATA bit 3 with a byte still queued
    store(32'h0020_0000, 32'(fv[12].data));
    store(32'h0020_0000, 32'h0000_0066);
    wait_start(ok);
    repeat (CPB * 4 + 1) begin
      @(posedge clk);
      #1;
    end
    check("mid_state_data", 32'(tx_state), 32'(DATA));
    check("mid_tx_bit3", 32'(uart_tx), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_tx", 32'(uart_tx), 32'd1);
    check("mid_rst_busy", 32'(console_busy), 32'd0);
    check("mid_rst_state", 32'(tx_state), 32'(IDLE));
    check("mid_rst_drop", 32'(drop_cnt), 32'd0);
    check("mid_rst_finish", 32'(finish), 32'd0);
    rst_n = 1'b1;
    idle_watch("mid_fifo_flushed", FRAME + 10);
    check("mid_busy_after", 32'(console_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
